// File: rtl/nios2_c_cpu_div_pkg.sv
// Shared constants for the Nios II iterative divide cell.
package nios2_c_cpu_div_pkg;

    // Default operand/result width.
    localparam int DIV_DATA_WIDTH = 32;

    // FSM encoding, kept as plain constants so the state register stays a
    // simple logic vector.
    typedef logic [1:0] div_state_t;
    localparam div_state_t S_IDLE = 2'd0;
    localparam div_state_t S_CALC = 2'd1;
    localparam div_state_t S_FIX  = 2'd2;
    localparam div_state_t S_DONE = 2'd3;

    // Quotient reported for a zero divisor.
    localparam logic [DIV_DATA_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/nios2_c_cpu_div_step.sv
// One combinational restoring-division iteration: shift {rem,quot} left by
// one, trial-subtract the divisor, keep the difference if it did not borrow.
module nios2_c_cpu_div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quot,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] next_rem,
    output logic [DATA_WIDTH-1:0] next_quot
);

    // Shifted partial remainder needs one extra bit; the subtract carries one
    // more so the borrow is an explicit bit rather than a compare.
    logic [DATA_WIDTH:0]   rem_sh;
    logic [DATA_WIDTH+1:0] diff;
    logic                  borrow;
    logic                  unused_diff_msb;

    assign rem_sh          = {rem, quot[DATA_WIDTH-1]};
    assign diff            = {1'b0, rem_sh} - {2'b00, divisor};
    assign borrow          = diff[DATA_WIDTH+1];
    // When no borrow occurs the difference is below the divisor, so this bit
    // is always zero on the path that uses diff.
    assign unused_diff_msb = diff[DATA_WIDTH];

    // Select restored or reduced remainder and shift in the quotient bit.
    always_comb begin
        next_quot = {quot[DATA_WIDTH-2:0], ~borrow};
        next_rem  = borrow ? rem_sh[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/nios2_c_cpu_div.sv
// This file holds the top-level divide cell.
// Iterative radix-2 restoring divider serving div/divu in the A stage.
// Start/done handshake with a fixed 34-cycle start-to-done latency.
module nios2_c_cpu_div_cell
    import nios2_c_cpu_div_pkg::*;
#(
    parameter int DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] A_div_src1,
    input  logic [DATA_WIDTH-1:0] A_div_src2,
    input  logic                  A_div_signed,
    input  logic                  A_div_start,
    input  logic                  A_div_kill,
    output logic                  A_div_busy,
    output logic                  A_div_done,
    output logic [DATA_WIDTH-1:0] A_div_quot,
    output logic [DATA_WIDTH-1:0] A_div_rem
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    div_state_t            state;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0] rem_w;
    logic [DATA_WIDTH-1:0] quot_w;
    logic [DATA_WIDTH-1:0] dvsr;
    logic                  q_neg;
    logic                  r_neg;
    logic                  div0;

    logic [DATA_WIDTH-1:0] abs1;
    logic [DATA_WIDTH-1:0] abs2;
    logic [DATA_WIDTH-1:0] step_rem;
    logic [DATA_WIDTH-1:0] step_quot;
    logic                  accept;

    // Status outputs decode straight from state so reset clears them at once.
    assign A_div_busy = (state == S_CALC) || (state == S_FIX);
    assign A_div_done = (state == S_DONE);

    // A start is taken whenever the cell is not busy; kill always blocks it.
    assign accept = A_div_start && !A_div_kill && !A_div_busy;

    // Operand magnitudes; -2^31 maps to 32'h80000000 read as unsigned.
    always_comb begin
        abs1 = (A_div_signed && A_div_src1[DATA_WIDTH-1]) ? -A_div_src1 : A_div_src1;
        abs2 = (A_div_signed && A_div_src2[DATA_WIDTH-1]) ? -A_div_src2 : A_div_src2;
    end

    nios2_c_cpu_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .rem       (rem_w),
        .quot      (quot_w),
        .divisor   (dvsr),
        .next_rem  (step_rem),
        .next_quot (step_quot)
    );

    // Sequencer: load on accept, iterate in CALC, sign-fix into outputs in FIX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            rem_w      <= '0;
            quot_w     <= '0;
            dvsr       <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            div0       <= 1'b0;
            A_div_quot <= '0;
            A_div_rem  <= '0;
        end else if (A_div_kill) begin
            // Flush: drop the operation, results keep the previous values.
            state <= S_IDLE;
        end else if (accept) begin
            state  <= S_CALC;
            cnt    <= '0;
            rem_w  <= '0;
            quot_w <= abs1;
            dvsr   <= abs2;
            q_neg  <= A_div_signed && (A_div_src1[DATA_WIDTH-1] ^ A_div_src2[DATA_WIDTH-1]);
            r_neg  <= A_div_signed && A_div_src1[DATA_WIDTH-1];
            div0   <= (A_div_src2 == '0);
        end else begin
            case (state)
                S_CALC: begin
                    rem_w  <= step_rem;
                    quot_w <= step_quot;
                    cnt    <= cnt + CNT_WIDTH'(1);
                    if (cnt == LAST_CNT) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    // With a zero divisor every step succeeds, leaving quot all
                    // ones and rem = |src1|; re-applying the dividend sign gives
                    // back src1 exactly, so only the quotient is overridden.
                    A_div_quot <= div0  ? DIV0_QUOT : (q_neg ? -quot_w : quot_w);
                    A_div_rem  <= r_neg ? -rem_w : rem_w;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_c_cpu_div_cell.sv
// Scoreboard bench for the divide cell: stimulus pushes expected results,
// a monitor pops and checks them (value and arrival cycle) on each done.
module tb_nios2_c_cpu_div_cell;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] A_div_src1 = '0;
    logic [31:0] A_div_src2 = '0;
    logic        A_div_signed = 1'b0;
    logic        A_div_start = 1'b0;
    logic        A_div_kill = 1'b0;
    logic        A_div_busy;
    logic        A_div_done;
    logic [31:0] A_div_quot;
    logic [31:0] A_div_rem;

    always #5 clk = ~clk;

    nios2_c_cpu_div_cell dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .A_div_src1   (A_div_src1),
        .A_div_src2   (A_div_src2),
        .A_div_signed (A_div_signed),
        .A_div_start  (A_div_start),
        .A_div_kill   (A_div_kill),
        .A_div_busy   (A_div_busy),
        .A_div_done   (A_div_done),
        .A_div_quot   (A_div_quot),
        .A_div_rem    (A_div_rem)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && A_div_done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done with no request pending (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, " quot"}, A_div_quot, e.q);
                chk({e.nm, " rem"},  A_div_rem,  e.r);
                chk({e.nm, " done_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Drive a start for one cycle; optionally record the expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic exp_en, input logic [31:0] q, input logic [31:0] r,
                         input string nm);
        exp_t e;
        A_div_src1   = a;
        A_div_src2   = b;
        A_div_signed = sg;
        A_div_start  = 1'b1;
        if (exp_en) begin
            e.q = q; e.r = r; e.cyc = cyc + 34; e.nm = nm;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        A_div_start = 1'b0;
    endtask

    // Bounded wait for all outstanding results.
    task automatic drain(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: %0d results pending, required 0", nm, sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'b0, A_div_busy}, 32'd0);
        chk("reset done", {31'b0, A_div_done}, 32'd0);
        chk("reset quot", A_div_quot, 32'd0);
        chk("reset rem",  A_div_rem,  32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1. divu 100/7 with busy window checks
        chk("t1 busy c0", {31'b0, A_div_busy}, 32'd0);
        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, "divu 100/7");
        chk("t1 busy c1", {31'b0, A_div_busy}, 32'd1);
        repeat (32) @(posedge clk);
        #1;
        chk("t1 busy c33", {31'b0, A_div_busy}, 32'd1);
        @(posedge clk); #1;
        chk("t1 busy c34", {31'b0, A_div_busy}, 32'd0);
        chk("t1 done c34", {31'b0, A_div_done}, 32'd1);
        drain("t1");

        // 2. signed truncate-toward-zero
        issue(32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, "div -7/2");
        drain("t2a");
        issue(32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'hFFFFFFFD, 32'd1, "div 7/-2");
        drain("t2b");

        // 3. signed overflow, and the same bits unsigned
        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h80000000, 32'd0, "div min/-1");
        drain("t3a");
        issue(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0, 32'h80000000, "divu 8000_0000/ffff_ffff");
        drain("t3b");

        // 4. divide by zero, both modes, plus a negative dividend
        issue(32'd1234, 32'd0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1234, "divu 1234/0");
        drain("t4a");
        issue(32'h80000000, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'h80000000, "div min/0");
        drain("t4b");
        issue(32'd1234, 32'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd1234, "div 1234/0");
        drain("t4c");

        // 5. kill at cycle 10, restart at cycle 11
        issue(32'd100, 32'd7, 1'b0, 1'b0, 32'd0, 32'd0, "killed");
        repeat (9) @(posedge clk);
        #1;
        A_div_kill = 1'b1;
        @(posedge clk); #1;
        A_div_kill = 1'b0;
        chk("t5 busy after kill", {31'b0, A_div_busy}, 32'd0);
        chk("t5 quot held", A_div_quot, 32'hFFFFFFFF);
        chk("t5 rem held",  A_div_rem,  32'd1234);
        issue(32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 32'd2, "after kill 100/7");
        drain("t5");

        // kill in IDLE suppresses a simultaneous start
        A_div_kill = 1'b1;
        issue(32'd5, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, "kill idle");
        A_div_kill = 1'b0;
        chk("idle kill busy", {31'b0, A_div_busy}, 32'd0);
        @(posedge clk); #1;
        chk("idle kill no done", {31'b0, A_div_done}, 32'd0);

        // 6. start held high: taken only at the idle/done cycles
        A_div_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            case (k)
                0: begin A_div_src1 = 32'd1000; A_div_src2 = 32'd10; A_div_signed = 1'b0;
                         e.q = 32'd100; e.r = 32'd0; end
                1: begin A_div_src1 = 32'hFFFFFF9C; A_div_src2 = 32'd7; A_div_signed = 1'b1;
                         e.q = 32'hFFFFFFF2; e.r = 32'hFFFFFFFE; end
                default: begin A_div_src1 = 32'd50; A_div_src2 = 32'd3; A_div_signed = 1'b0;
                         e.q = 32'd16; e.r = 32'd2; end
            endcase
            e.cyc = cyc + 34;
            e.nm  = $sformatf("b2b op%0d", k);
            sb.push_back(e);
            @(posedge clk); #1;
            // Operands seen while busy must be ignored.
            A_div_src1 = 32'd9; A_div_src2 = 32'd9; A_div_signed = 1'b0;
            if (k < 2) begin
                repeat (33) @(posedge clk);
                #1;
            end
        end
        repeat (19) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async reset busy", {31'b0, A_div_busy}, 32'd0);
        chk("async reset done", {31'b0, A_div_done}, 32'd0);
        chk("async reset quot", A_div_quot, 32'd0);
        chk("async reset rem",  A_div_rem,  32'd0);
        chk("pending before reset", 32'(sb.size()), 32'd1);
        if (sb.size() != 0) void'(sb.pop_back());
        A_div_start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("no done after reset", 32'(sb.size()), 32'd0);
        chk("idle after reset", {31'b0, A_div_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
